// File: rtl/gpu_wb_pkg.sv
// gpu_wb_pkg: shared types and constants for the GPU Wishbone host slice.
package gpu_wb_pkg;
    localparam int WB_ADDR_W = 27;
    localparam int WB_DATA_W = 32;
    localparam int CMD_W     = 1 + 4 + WB_ADDR_W + WB_DATA_W;

    // GPU port address map
    localparam logic [WB_ADDR_W-1:0] CR_BASE     = 27'h000_0000;
    localparam logic [WB_ADDR_W-1:0] SPRITE_BASE = 27'h000_0100;
    localparam logic [WB_ADDR_W-1:0] SPRITE_LAST = 27'h000_0FFF;
    localparam logic [WB_ADDR_W-1:0] TILE_BASE   = 27'h000_1000;
    localparam logic [WB_ADDR_W-1:0] TEX_BASE    = 27'h000_2000;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP} wb_state_e;

    typedef struct packed {
        logic                 we;
        logic [3:0]           sel;
        logic [WB_ADDR_W-1:0] adr;
        logic [WB_DATA_W-1:0] dat;
    } wb_cmd_t;
endpackage

// File: rtl/gpu_wb_cmd_fifo.sv
// gpu_wb_cmd_fifo: first-word-fall-through command FIFO on registered storage.
module gpu_wb_cmd_fifo
    import gpu_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [CMD_W-1:0]        din_i,
    output logic [CMD_W-1:0]        dout_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q;
    logic             push, pop;

    assign push    = push_i && !full_o;
    assign pop     = pop_i && !empty_o;
    assign full_o  = count_q == (AW + 1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din_i;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            count_q <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end
endmodule

// File: rtl/gpu_wb_host.sv
// gpu_wb_host: Wishbone classic initiator with a command FIFO and an enforced idle gap between cycles.
// Define GPU_WB_HOST_TIMEOUT_EN to abort REQ after TIMEOUT_CYCLES without ack.
module gpu_wb_host
    import gpu_wb_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_we,
    input  logic [WB_ADDR_W-1:0] i_cmd_addr,
    input  logic [WB_DATA_W-1:0] i_cmd_data,
    input  logic [3:0]           i_cmd_sel,
    output logic                 o_rsp_valid,
    output logic [WB_DATA_W-1:0] o_rsp_data,
    output logic                 o_rsp_err,
    output logic                 o_busy,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [3:0]           wb_sel_o,
    output logic [WB_ADDR_W-1:0] wb_adr_o,
    output logic [WB_DATA_W-1:0] wb_dat_o,
    input  logic [WB_DATA_W-1:0] wb_dat_i,
    input  logic                 wb_ack_i
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int CW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || GAP_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("gpu_wb_host: unsupported parameter set");
    end

    wb_state_e            state_q;
    logic [GW-1:0]        gap_q;
    logic                 cyc_q, we_q, rsp_valid_q;
    logic [3:0]           sel_q;
    logic [WB_ADDR_W-1:0] adr_q;
    logic [WB_DATA_W-1:0] dat_q, rsp_data_q;
    wb_cmd_t              head;
    logic                 empty, full, pop, to_hit;
    logic [CW:0]          count;

    assign pop = (state_q == ST_IDLE) && !empty;

    gpu_wb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (i_cmd_valid),
        .pop_i   (pop),
        .din_i   ({i_cmd_we, i_cmd_sel, i_cmd_addr, i_cmd_data}),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign o_cmd_ready = !full;
    assign o_busy      = (state_q != ST_IDLE) || (count != '0);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_sel_o    = sel_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;

`ifdef GPU_WB_HOST_TIMEOUT_EN
    logic [15:0] to_q;
    logic        err_q;

    assign to_hit    = to_q == 16'(TIMEOUT_CYCLES - 1);
    assign o_rsp_err = err_q;

    // Held at zero outside REQ, so every REQ entry starts from a cleared count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            to_q  <= (state_q == ST_REQ) ? to_q + 16'd1 : '0;
            err_q <= (state_q == ST_REQ) && to_hit && !wb_ack_i;
        end
    end
`else
    assign to_hit    = 1'b0;
    assign o_rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            gap_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (!empty) begin
                    we_q    <= head.we;
                    sel_q   <= head.sel;
                    adr_q   <= head.adr;
                    dat_q   <= head.dat;
                    cyc_q   <= 1'b1;
                    state_q <= ST_REQ;
                end
                // An ack coinciding with the terminal count takes priority over the abort.
                ST_REQ: if (wb_ack_i || to_hit) begin
                    cyc_q       <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= (we_q || !wb_ack_i) ? '0 : wb_dat_i;
                    gap_q       <= GW'(GAP_CYCLES - 1);
                    state_q     <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_q == '0) state_q <= ST_IDLE;
                    else gap_q <= gap_q - GW'(1);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpu_wb_host.sv
// tb_gpu_wb_host: directed self-checking bench for gpu_wb_host against a configurable Wishbone slave.
module tb_gpu_wb_host;
    import gpu_wb_pkg::*;

    localparam int GAP = 2;

    logic                 clk = 1'b0, reset_n = 1'b1;
    logic                 i_cmd_valid = 1'b0, i_cmd_we = 1'b0;
    logic [WB_ADDR_W-1:0] i_cmd_addr = '0;
    logic [WB_DATA_W-1:0] i_cmd_data = '0;
    logic [3:0]           i_cmd_sel = '0;
    logic                 o_cmd_ready, o_rsp_valid, o_rsp_err, o_busy;
    logic [WB_DATA_W-1:0] o_rsp_data, wb_dat_o, wb_dat_i;
    logic                 wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [3:0]           wb_sel_o;
    logic [WB_ADDR_W-1:0] wb_adr_o;

    int checks = 0, failures = 0;

    gpu_wb_host #(.FIFO_DEPTH(4), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
        .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_sel(i_cmd_sel),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err), .o_busy(o_busy),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    // Slave: registered ack sl_delay+1 edges after stb is seen, held for sl_hold extra cycles.
    int   sl_delay = 0, sl_hold = 0, sl_cnt = 0, sl_hcnt = 0;
    logic sl_never = 1'b0, sl_fixed = 1'b0, sl_ack = 1'b0, ack_force = 1'b0;
    logic [31:0] sl_rdata = '0;

    assign wb_ack_i = sl_ack | ack_force;
    assign wb_dat_i = sl_fixed ? sl_rdata : {5'h1A, wb_adr_o};

    always @(posedge clk) begin
        if (sl_ack) begin
            if (sl_hcnt >= sl_hold) begin sl_ack <= 1'b0; sl_hcnt <= 0; end
            else sl_hcnt <= sl_hcnt + 1;
        end else if (wb_cyc_o && wb_stb_o && !sl_never) begin
            if (sl_cnt >= sl_delay) begin sl_ack <= 1'b1; sl_cnt <= 0; end
            else sl_cnt <= sl_cnt + 1;
        end else sl_cnt <= 0;
    end

    // Monitor: edge counter plus logs of responses, cyc rises and stb-high cycles.
    int cyc_t = 0, stb_cycles = 0, overlap = 0;
    logic cyc_prev = 1'b0;
    logic [31:0] rsp_d[$];
    logic        rsp_e[$];
    int          rsp_t[$], rise_t[$];

    always @(posedge clk) cyc_t <= cyc_t + 1;

    always @(negedge clk) begin
        if (o_rsp_valid) begin
            rsp_d.push_back(o_rsp_data);
            rsp_e.push_back(o_rsp_err);
            rsp_t.push_back(cyc_t);
            if (wb_cyc_o || wb_stb_o) overlap++;
        end
        if (wb_cyc_o && !cyc_prev) rise_t.push_back(cyc_t);
        if (wb_stb_o) stb_cycles++;
        cyc_prev = wb_cyc_o;
    end

    task automatic push(input logic we, input logic [WB_ADDR_W-1:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output int e);
        @(negedge clk);
        i_cmd_valid = 1'b1; i_cmd_we = we; i_cmd_addr = adr; i_cmd_data = dat; i_cmd_sel = sel;
        for (int i = 0; i < 400 && !o_cmd_ready; i++) @(negedge clk);
        e = cyc_t + 1;
        @(posedge clk);
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 400 && rsp_d.size() < target; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b want=000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
        checks++; if ({wb_sel_o, wb_adr_o, wb_dat_o} !== 63'd0) begin failures++; $display("FAIL reset_bus got=%h want=0", {wb_sel_o, wb_adr_o, wb_dat_o}); end
        checks++; if ({o_rsp_valid, o_rsp_data, o_rsp_err, o_busy} !== 35'd0) begin failures++; $display("FAIL reset_rsp got=%h want=0", {o_rsp_valid, o_rsp_data, o_rsp_err, o_busy}); end
        checks++; if (o_cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", o_cmd_ready); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        int e, r0, s0, f0, o0;
        sl_delay = 2; sl_hold = 0; sl_never = 1'b0; sl_fixed = 1'b0;
        r0 = rsp_d.size(); s0 = stb_cycles; f0 = rise_t.size(); o0 = overlap;
        push(1'b1, CR_BASE, 32'h0000_0015, 4'hF, e);
        @(negedge clk); i_cmd_valid = 1'b0;
        checks++; if (wb_cyc_o !== 1'b0) begin failures++; $display("FAIL wr_cyc_early got=%b want=0", wb_cyc_o); end
        @(negedge clk);
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o} !== {3'b111, 4'hF, 27'h0, 32'h15})
            begin failures++; $display("FAIL wr_bus got=%h want=%h", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}, {3'b111, 4'hF, 27'h0, 32'h15}); end
        wait_rsp(r0 + 1);
        repeat (GAP + 4) @(negedge clk);
        checks++; if (rsp_d.size() != r0 + 1) begin failures++; $display("FAIL wr_rsp_count got=%0d want=%0d", rsp_d.size() - r0, 1); end
        checks++; if (rsp_t[r0] != e + 5) begin failures++; $display("FAIL wr_rsp_time got=%0d want=%0d", rsp_t[r0], e + 5); end
        checks++; if ({rsp_e[r0], rsp_d[r0]} !== 33'd0) begin failures++; $display("FAIL wr_rsp_val got=%h want=0", {rsp_e[r0], rsp_d[r0]}); end
        checks++; if (stb_cycles - s0 != 4) begin failures++; $display("FAIL wr_stb_cycles got=%0d want=4", stb_cycles - s0); end
        checks++; if (rise_t.size() - f0 != 1 || wb_cyc_o !== 1'b0) begin failures++; $display("FAIL wr_single_pulse got=%0d want=1", rise_t.size() - f0); end
        checks++; if (overlap != o0) begin failures++; $display("FAIL wr_rsp_cyc_overlap got=%0d want=0", overlap - o0); end
    endtask

    task automatic test_read();
        int e, r0, f0;
        sl_delay = 1; sl_hold = 1; sl_fixed = 1'b1; sl_rdata = 32'hA5A5_0003;
        r0 = rsp_d.size(); f0 = rise_t.size();
        push(1'b0, TILE_BASE + 27'h4, 32'hFFFF_FFFF, 4'hF, e);
        @(negedge clk); i_cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if ({wb_cyc_o, wb_we_o, wb_adr_o} !== {2'b10, 27'h1004}) begin failures++; $display("FAIL rd_bus got=%h want=%h", {wb_cyc_o, wb_we_o, wb_adr_o}, {2'b10, 27'h1004}); end
        wait_rsp(r0 + 1);
        repeat (10) @(negedge clk);
        checks++; if (rsp_d.size() != r0 + 1) begin failures++; $display("FAIL rd_stale_ack_rsp got=%0d want=1", rsp_d.size() - r0); end
        checks++; if (rsp_d[r0] !== 32'hA5A5_0003 || rsp_e[r0] !== 1'b0) begin failures++; $display("FAIL rd_data got=%h want=a5a50003", rsp_d[r0]); end
        checks++; if (rise_t.size() - f0 != 1) begin failures++; $display("FAIL rd_pulses got=%0d want=1", rise_t.size() - f0); end
        sl_fixed = 1'b0; sl_hold = 0;
    endtask

    task automatic test_back_to_back();
        int e0, e, e5, r0, o0;
        logic [31:0] exp_d [6];
        exp_d = '{32'hD000_2000, 32'hD000_2004, 32'h0, 32'hD000_200C, 32'hD000_2010, 32'hD000_2014};
        sl_delay = 6; r0 = rsp_d.size(); o0 = overlap;
        push(1'b0, TEX_BASE, 32'h0, 4'hF, e0);
        push(1'b0, TEX_BASE + 27'h4, 32'h0, 4'hF, e);
        push(1'b1, TEX_BASE + 27'h8, 32'h11, 4'h3, e);
        push(1'b0, TEX_BASE + 27'hC, 32'h0, 4'hF, e);
        push(1'b0, TEX_BASE + 27'h10, 32'h0, 4'hF, e);
        @(negedge clk); i_cmd_valid = 1'b0;
        checks++; if (o_cmd_ready !== 1'b0 || e != e0 + 4) begin failures++; $display("FAIL b2b_full got=%b want=0", o_cmd_ready); end
        push(1'b0, TEX_BASE + 27'h14, 32'h0, 4'hF, e5);
        @(negedge clk); i_cmd_valid = 1'b0;
        checks++; if (e5 != e0 + 13) begin failures++; $display("FAIL b2b_fifth_accept got=%0d want=%0d", e5 - e0, 13); end
        wait_rsp(r0 + 6);
        repeat (5) @(negedge clk);
        checks++; if (rsp_d.size() != r0 + 6) begin failures++; $display("FAIL b2b_rsp_count got=%0d want=6", rsp_d.size() - r0); end
        for (int i = 0; i < 6; i++) begin
            checks++; if ({rsp_e[r0 + i], rsp_d[r0 + i]} !== {1'b0, exp_d[i]}) begin failures++; $display("FAIL b2b_order[%0d] got=%h want=%h", i, rsp_d[r0 + i], exp_d[i]); end
        end
        checks++; if (overlap != o0 || o_busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_end got=%0d want=0", overlap - o0); end
    endtask

    task automatic test_throughput();
        int e, e1, f0;
        sl_delay = 0; f0 = rise_t.size();
        push(1'b1, CR_BASE + 27'h8, 32'h1, 4'hF, e);
        push(1'b1, CR_BASE + 27'hC, 32'h2, 4'hF, e1);
        @(negedge clk); i_cmd_valid = 1'b0;
        wait_rsp(rsp_d.size() + 2);
        repeat (5) @(negedge clk);
        checks++; if (rise_t[f0] != e + 1) begin failures++; $display("FAIL tp_first_rise got=%0d want=%0d", rise_t[f0], e + 1); end
        checks++; if (rise_t[f0 + 1] - rise_t[f0] != 3 + GAP) begin failures++; $display("FAIL tp_period got=%0d want=%0d", rise_t[f0 + 1] - rise_t[f0], 3 + GAP); end
    endtask

`ifdef GPU_WB_HOST_TIMEOUT_EN
    task automatic test_timeout();
        int e, e1, r0, s0;
        sl_delay = 0; sl_never = 1'b1; r0 = rsp_d.size(); s0 = stb_cycles;
        push(1'b0, TEX_BASE + 27'h40, 32'h0, 4'hF, e);
        push(1'b0, TEX_BASE + 27'h44, 32'h0, 4'hF, e1);
        @(negedge clk); i_cmd_valid = 1'b0;
        wait_rsp(r0 + 1);
        sl_never = 1'b0;
        checks++; if (stb_cycles - s0 != 16) begin failures++; $display("FAIL to_req_cycles got=%0d want=16", stb_cycles - s0); end
        wait_rsp(r0 + 2);
        checks++; if (rsp_t[r0] != e + 17) begin failures++; $display("FAIL to_rsp_time got=%0d want=%0d", rsp_t[r0], e + 17); end
        checks++; if ({rsp_e[r0], rsp_d[r0]} !== {1'b1, 32'h0}) begin failures++; $display("FAIL to_rsp_err got=%h want=100000000", {rsp_e[r0], rsp_d[r0]}); end
        checks++; if ({rsp_e[r0 + 1], rsp_d[r0 + 1]} !== {1'b0, 32'hD000_2044}) begin failures++; $display("FAIL to_next_cmd got=%h want=0d0002044", {rsp_e[r0 + 1], rsp_d[r0 + 1]}); end
        repeat (5) @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid();
        int e, r0, f0;
        sl_never = 1'b1; r0 = rsp_d.size(); f0 = rise_t.size();
        push(1'b0, TEX_BASE + 27'h80, 32'h0, 4'hF, e);
        push(1'b1, TEX_BASE + 27'h84, 32'h5, 4'hF, e);
        push(1'b0, TEX_BASE + 27'h88, 32'h0, 4'hF, e);
        @(negedge clk); i_cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (wb_cyc_o !== 1'b1) begin failures++; $display("FAIL rst_mid_in_req got=%b want=1", wb_cyc_o); end
        @(posedge clk); #2 reset_n = 1'b0; #1;
        checks++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin failures++; $display("FAIL rst_mid_async_drop got=%b want=00", {wb_cyc_o, wb_stb_o}); end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1; sl_never = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if ({o_busy, o_cmd_ready} !== 2'b01) begin failures++; $display("FAIL rst_mid_status got=%b want=01", {o_busy, o_cmd_ready}); end
        checks++; if (rsp_d.size() != r0 || rise_t.size() != f0 + 1) begin failures++; $display("FAIL rst_mid_no_rsp got=%0d want=0", rsp_d.size() - r0); end
    endtask

    task automatic test_idle_ack();
        int r0;
        r0 = rsp_d.size();
        @(negedge clk); ack_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({o_rsp_valid, wb_cyc_o, o_busy} !== 3'b000) begin failures++; $display("FAIL idle_ack[%0d] got=%b want=000", i, {o_rsp_valid, wb_cyc_o, o_busy}); end
        end
        ack_force = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rsp_d.size() != r0 || o_busy !== 1'b0) begin failures++; $display("FAIL idle_ack_after got=%0d want=0", rsp_d.size() - r0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_throughput();
`ifdef GPU_WB_HOST_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        test_idle_ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
